level_pulse_gen: RTL and testbench

- Transmit-side counterpart of the rising-edge tick detector.
- Converts single-cycle request ticks into clean level pulses: high for HIGH_CYCLES, then low for at least LOW_CYCLES.
- A downstream edge detector therefore sees exactly one rising edge per accepted request.
- Requests arriving while a pulse is in flight are queued in a saturating pending counter.

---
 rtl/pulse_pkg.sv | 20 ++
 rtl/pulse_sat_counter.sv | 27 ++
 rtl/level_pulse_gen.sv | 125 ++++++++++++
 tb/tb_level_pulse_gen.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared types for the level pulse generator: FSM state encoding and a
// width helper for the duration counter.
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pulse_state_e;

    // The counter must hold max(high, low) - 1, and is never narrower than one bit.
    function automatic int cnt_width(input int high_cycles, input int low_cycles);
        int m;
        int w;
        m = (high_cycles > low_cycles) ? high_cycles : low_cycles;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pulse_sat_counter.sv
// Saturating up/down counter. A simultaneous inc and dec cancel out, so an
// increment is never lost while the counter is full.
module pulse_sat_counter #(
    parameter int MAX = 3,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         at_max
);

    assign at_max = (count == W'(MAX));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && !dec && !at_max) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/level_pulse_gen.sv
// Turns single-cycle request ticks into level pulses (HIGH_CYCLES high, at
// least LOW_CYCLES low), queueing overlapping requests. Define
// LEVEL_PULSE_GEN_OVF_EN to add a sticky ovf output flagging dropped requests.
module level_pulse_gen
    import pulse_pkg::*;
#(
    parameter int HIGH_CYCLES = 2,
    parameter int LOW_CYCLES  = 2,
    parameter int PEND_MAX    = 3,
    parameter int PW          = $clog2(PEND_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          level,
    output logic          busy,
    output logic [PW-1:0] pending
`ifdef LEVEL_PULSE_GEN_OVF_EN
    ,
    output logic          ovf
`endif
);

    localparam int CW = cnt_width(HIGH_CYCLES, LOW_CYCLES);

    pulse_state_e  state;
    pulse_state_e  state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;

    logic cnt_zero;
    logic low_done;
    logic have_pend;
    logic consume;
    logic direct;
    logic inc;
    logic at_max;
    logic drop;

    assign cnt_zero  = (cnt == '0);
    assign low_done  = (state == LOW) && cnt_zero;
    assign have_pend = (pending != '0);
    assign consume   = low_done && have_pend;
    // A request landing exactly at the end of LOW with nothing queued starts
    // the next pulse itself and never enters the queue.
    assign direct    = low_done && !have_pend && req;
    assign inc       = req && (state != IDLE) && !direct;
    assign drop      = inc && !consume && at_max;

    pulse_sat_counter #(
        .MAX (PEND_MAX),
        .W   (PW)
    ) u_pending (
        .clk    (clk),
        .reset  (reset),
        .inc    (inc),
        .dec    (consume),
        .count  (pending),
        .at_max (at_max)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    state_n = HIGH;
                    cnt_n   = CW'(HIGH_CYCLES - 1);
                end
            end
            HIGH: begin
                if (!cnt_zero) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    state_n = LOW;
                    cnt_n   = CW'(LOW_CYCLES - 1);
                end
            end
            LOW: begin
                if (!cnt_zero) begin
                    cnt_n = cnt - 1'b1;
                end else if (have_pend || req) begin
                    state_n = HIGH;
                    cnt_n   = CW'(HIGH_CYCLES - 1);
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            level <= (state_n == HIGH);
            busy  <= (state_n != IDLE);
        end
    end

`ifdef LEVEL_PULSE_GEN_OVF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_level_pulse_gen.sv
// Directed bench for level_pulse_gen: default instance plus a 1/1/1 variant.
module tb_level_pulse_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req = 1'b0;
    logic       req_min = 1'b0;
    logic       level;
    logic       busy;
    logic [1:0] pending;
    logic       level_min;
    logic       busy_min;
    logic [0:0] pending_min;
`ifdef LEVEL_PULSE_GEN_OVF_EN
    logic       ovf;
    logic       ovf_min;
`endif

    int vectors = 0;
    int miscompares = 0;

    // 6 requests on consecutive edges, then 15 idle edges.
    int q_lv [0:20] = '{1,1,0,0,1,1,0,0,1,1,0,0,1,1,0,0,1,1,0,0,0};
    int q_by [0:20] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0};
    int q_pd [0:20] = '{0,1,2,3,3,3,3,3,2,2,2,2,1,1,1,1,0,0,0,0,0};
    // Requests at relative edges 0 and 4 only.
    int b_lv [0:8]  = '{1,1,0,0,1,1,0,0,0};
    int b_by [0:8]  = '{1,1,1,1,1,1,1,1,0};
    // HIGH=LOW=PEND_MAX=1 instance with req on every edge.
    int m_lv [0:7]  = '{1,0,1,0,1,0,1,0};
    int m_pd [0:7]  = '{0,1,1,1,1,1,1,1};

    always #5 clk = ~clk;

    level_pulse_gen u_dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .level   (level),
        .busy    (busy),
        .pending (pending)
`ifdef LEVEL_PULSE_GEN_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    level_pulse_gen #(
        .HIGH_CYCLES (1),
        .LOW_CYCLES  (1),
        .PEND_MAX    (1)
    ) u_min (
        .clk     (clk),
        .reset   (reset),
        .req     (req_min),
        .level   (level_min),
        .busy    (busy_min),
        .pending (pending_min)
`ifdef LEVEL_PULSE_GEN_OVF_EN
        ,
        .ovf     (ovf_min)
`endif
    );

    task automatic chk(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic chk3(input string tag, input int l, input int b, input int p);
        chk({tag, ".level"}, int'(level), l);
        chk({tag, ".busy"}, int'(busy), b);
        chk({tag, ".pending"}, int'(pending), p);
    endtask

    task automatic tick(input logic r);
        req = r;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    initial begin
        // Held in reset with req toggling
        for (int i = 0; i < 3; i++) begin
            tick(i[0] == 1'b0);
            chk3($sformatf("rst%0d", i), 0, 0, 0);
`ifdef LEVEL_PULSE_GEN_OVF_EN
            chk($sformatf("rst%0d.ovf", i), int'(ovf), 0);
`endif
        end
        reset = 1'b1;
        tick(1'b0);
        tick(1'b0);
        chk3("idle", 0, 0, 0);

        // Single request
        tick(1'b1);
        chk3("single0", 1, 1, 0);
        tick(1'b0);
        chk3("single1", 1, 1, 0);
        tick(1'b0);
        chk3("single2", 0, 1, 0);
        tick(1'b0);
        chk3("single3", 0, 1, 0);
        tick(1'b0);
        chk3("single4", 0, 0, 0);
        tick(1'b0);

        // Six back-to-back requests: queue fills, one is dropped
        for (int i = 0; i < 21; i++) begin
            tick(i < 6);
            chk3($sformatf("queue%0d", i), q_lv[i], q_by[i], q_pd[i]);
`ifdef LEVEL_PULSE_GEN_OVF_EN
            chk($sformatf("queue%0d.ovf", i), int'(ovf), (i >= 5) ? 1 : 0);
`endif
        end
        tick(1'b0);

        // Second request exactly at the end of LOW: no IDLE gap
        for (int i = 0; i < 9; i++) begin
            tick((i == 0) || (i == 4));
            chk3($sformatf("b2b%0d", i), b_lv[i], b_by[i], 0);
        end

        // Asynchronous reset mid-HIGH with two queued requests
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        chk3("prerst", 1, 1, 2);
        #2;
        reset = 1'b0;
        #1;
        chk3("asyncrst", 0, 0, 0);
        tick(1'b0);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0);
            chk3($sformatf("postrst%0d", i), 0, 0, 0);
        end
`ifdef LEVEL_PULSE_GEN_OVF_EN
        chk("postrst.ovf", int'(ovf), 0);
`endif

        // Minimal-parameter instance, request on every edge
        for (int i = 0; i < 8; i++) begin
            req_min = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("min%0d.level", i), int'(level_min), m_lv[i]);
            chk($sformatf("min%0d.pending", i), int'(pending_min), m_pd[i]);
            chk($sformatf("min%0d.busy", i), int'(busy_min), 1);
        end
`ifdef LEVEL_PULSE_GEN_OVF_EN
        chk("min.ovf", int'(ovf_min), 1);
`endif
        req_min = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
